// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// No logic here. Used by mem_arbiter and arb_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Wide enough for the largest legal WAIT_CYCLES-1 (14).
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and data; MEM_ARB_RR_EN selects round-robin, else data-over-fetch.
// Zero latency; pure function of the current requests and last winner, no backpressure.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic last_winner_i,
  output logic pick_vld_o,
  output logic pick_id_o
);

  assign pick_vld_o = if_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    pick_id_o = REQ_DATA;
    if (if_req_i && d_req_i) begin
      // On a tie, the requester that did not win last time goes first.
      pick_id_o = (last_winner_i == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (if_req_i) begin
      pick_id_o = REQ_FETCH;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_winner_i;

  always_comb begin
    pick_id_o = REQ_DATA;
    if (if_req_i && !d_req_i) begin
      pick_id_o = REQ_FETCH;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data requesters (MEM_ARB_RR_EN: round-robin ties).
// Latency: gnt at N+1, rvalid at N+WAIT_CYCLES+1; requests are only sampled in IDLE, requesters hold until gnt.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  import mem_arb_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               own_q;
  logic               last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q;
  logic               mem_en_q;
  logic               busy_q;
  logic               if_gnt_q;
  logic               d_gnt_q;
  logic               if_rvalid_q;
  logic               d_rvalid_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;
  logic               pick_vld_d;
  logic               pick_id_d;

  arb_pick u_pick (
    .if_req_i      (if_req),
    .d_req_i       (d_req),
    .last_winner_i (last_q),
    .pick_vld_o    (pick_vld_d),
    .pick_id_o     (pick_id_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_q       <= REQ_FETCH;
      last_q      <= REQ_FETCH;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q  <= ACCESS;
            cnt_q    <= CNT_LOAD;
            own_q    <= pick_id_d;
            last_q   <= pick_id_d;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            if (pick_id_d == REQ_DATA) begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              we_q    <= d_we;
              d_gnt_q <= 1'b1;
            end else begin
              addr_q   <= if_addr;
              wdata_q  <= '0;
              we_q     <= 1'b0;
              if_gnt_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q  <= RESP;
            mem_en_q <= 1'b0;
            we_q     <= 1'b0;
            // Stores complete with rvalid but must not disturb the held load data.
            if (!we_q) begin
              if (own_q == REQ_DATA) d_rdata_q  <= mem_rdata;
              else                   if_rdata_q <= mem_rdata;
            end
            if (own_q == REQ_DATA) d_rvalid_q  <= 1'b1;
            else                   if_rvalid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (feeds IR) and the data load/store requester (ALUOut address, B write data, MDR capture).
- Sits between the multi-cycle CPU datapath/control unit and the memory, replacing separate IMem/DMem.
- Sequences each access through a fixed-latency memory with a ready/valid-style grant/response handshake.
- Arbitration between the two requesters is fixed-priority, or round-robin when the optional feature is compiled in.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, cycles the memory needs with inputs held stable before mem_rdata is valid (legal range is 1 to 15).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address (the PC).
- if_gnt  out  1  fetch grant pulse.
- if_rvalid  out  1  fetch data valid pulse.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data grant pulse.
- d_rvalid  out  1  data completion pulse (both loads and stores).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs are 0, FSM is in IDLE, wait counter is 0, last-winner register is FETCH.
- Reset mid-access aborts the access with no rvalid. mem_en is 0 in the cycle after reset is sampled.
- FSM states:
  - IDLE: samples if_req and d_req. If either is high, selects a winner, registers the winner's address, write data and we (fetch we is forced 0), and moves to ACCESS. If neither is high, stays in IDLE.
  - ACCESS: lasts exactly WAIT_CYCLES cycles, counted by a counter loaded with WAIT_CYCLES-1 on entry. mem_en is 1 and mem_addr, mem_we and mem_wdata come from the registers, stable for the whole state. When the counter reaches 0:
    - on a read, mem_rdata is captured into the winner's rdata register;
    - the FSM moves to RESP.
  - RESP: the winner's rvalid is 1 for one cycle, mem_en is 0, and the FSM moves to IDLE.
- Grant: the winner's gnt is 1 for one cycle, in the first ACCESS cycle.
- Timing (request sampled in IDLE at cycle N):
  - gnt at N+1;
  - mem_en high for cycles N+1 to N+WAIT_CYCLES;
  - rvalid at N+WAIT_CYCLES+1;
  - back in IDLE at N+WAIT_CYCLES+2.
- Minimum spacing between accesses is WAIT_CYCLES+2 cycles. There is no back-to-back pipelining.
- Requester rules:
  - A requester holds req and its address/data stable until it sees its gnt.
  - It may drop req before gnt; the arbiter only samples requests in IDLE.
  - Request inputs are ignored outside IDLE.
  - If req is still high at the next IDLE, a new access starts.
- rdata registers: if_rdata and d_rdata hold their value until the next read completion for that requester. A store completion pulses d_rvalid but leaves d_rdata unchanged.
- Simultaneous if_req and d_req in IDLE: data wins (fixed priority). This completes the pending MEM/WB stage before the next fetch.
- The last-winner register updates on every grant.
- WAIT_CYCLES=1: ACCESS lasts one cycle; gnt and mem_en are asserted in the same single cycle.
- Only one gnt or rvalid is ever high at a time. gnt and rvalid are never asserted in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on a simultaneous request, the requester that did not win last is granted (round-robin using the last-winner register). A single request is always granted.
- Undefined: fixed data-over-fetch priority. The last-winner register is kept but does not affect selection.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - requester ID constants REQ_FETCH=0 and REQ_DATA=1;
  - the WAIT counter width constant (4 bits).
- One sub-module, arb_pick: combinational winner select from if_req, d_req and last_winner. It contains the MEM_ARB_RR_EN conditional.
- Everything else (FSM, counter, registers) stays in mem_arbiter.

Test Plan:
- Fetch read: reset released, WAIT_CYCLES=2, if_req=1, if_addr=0x0000_0010, memory returns 0x2008_0005 -> if_gnt at cycle 1; mem_en high in cycles 1 and 2 with mem_addr=0x10 and mem_we=0; if_rvalid=1 at cycle 3 with if_rdata=0x2008_0005; busy=0 at cycle 4.
- Data store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF -> mem_we=1 with mem_wdata=0xDEADBEEF for 2 cycles; d_rvalid pulse; d_rdata unchanged from its prior value.
- Simultaneous requests: if_req and d_req both 1 and held through two accesses ->
  - without MEM_ARB_RR_EN: both grants go to data;
  - with MEM_ARB_RR_EN: grants are data then fetch (last winner at reset = FETCH).
- Reset mid-ACCESS: reset=0 in cycle 2 of a load -> next cycle mem_en=0, busy=0, no d_rvalid; a fresh if_req then completes normally.
- Request dropped and ignored: if_req pulsed during ACCESS of a data access, then dropped before IDLE -> no fetch grant issued.
- WAIT_CYCLES=1 build: d_req load of 0x1234 -> d_gnt and mem_en in cycle 1, d_rvalid at cycle 2, d_rdata=0x1234.
